taylor_term_gen: RTL and testbench

- Upstream producer for the exp(x) Taylor-series summation tree: for a single-precision IEEE-754 x, streams the terms x^k/k! for k = 0..n-1 in order.
- Replaces hand-loaded power/reciprocal-factorial operand pairs with a sequential generator.
- Uses one time-multiplexed FP multiplier, an internal reciprocal-factorial ROM and a valid/ready output port that feeds the adder stage.

---
 rtl/taylor_pkg.sv | 33 +++
 rtl/fp_mul32.sv | 53 +++++
 rtl/taylor_term_gen.sv | 156 +++++++++++++++
 tb/tb_taylor_term_gen.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/taylor_pkg.sv
// Shared definitions for the exp(x) Taylor-term generator.
//   - IEEE-754 single-precision field widths and bias
//   - ONE_F   : 1.0 encoding, initial value of the power register
//   - RF_ROM  : 1/k! for k = 0..7, single precision
//   - state_e : generator sequencing states
package taylor_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned BIAS  = 127;

  localparam logic [31:0] ONE_F = 32'h3F80_0000;

  localparam logic [31:0] RF_ROM [0:7] = '{
    32'h3F80_0000,  // 1/0!
    32'h3F80_0000,  // 1/1!
    32'h3F00_0000,  // 1/2!
    32'h3E2A_AAAB,  // 1/3!
    32'h3D2A_AAAB,  // 1/4!
    32'h3C08_8889,  // 1/5!
    32'h3AB6_0B61,  // 1/6!
    32'h3950_0D01   // 1/7!
  };

  typedef enum logic [2:0] {
    IDLE,
    TERM,
    OUT,
    POW,
    DONE
  } state_e;

endpackage

// File: rtl/fp_mul32.sv
// Combinational single-precision multiplier.
//   a, b : IEEE-754 operands
//   y    : a*b, truncated, flush-to-zero on zero/denormal inputs or
//          underflow, signed infinity on overflow or inf/NaN inputs.
module fp_mul32
  import taylor_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic             s;
  logic [EXP_W-1:0] ea;
  logic [EXP_W-1:0] eb;
  logic [MAN_W:0]   fa;
  logic [MAN_W:0]   fb;
  logic [47:0]      prod;
  logic             norm;
  logic [MAN_W-1:0] man;
  logic signed [9:0] exp_s;
  logic             unused_low;

  always_comb begin
    s     = a[31] ^ b[31];
    ea    = a[30:23];
    eb    = b[30:23];
    fa    = {1'b1, a[22:0]};
    fb    = {1'b1, b[22:0]};
    prod  = {24'b0, fa} * {24'b0, fb};
    // Product of two [1,2) significands lies in [1,4): one shift at most.
    norm  = prod[47];
    man   = norm ? prod[46:24] : prod[45:23];
    exp_s = $signed({2'b0, ea}) + $signed({2'b0, eb})
          - 10'sd127 + $signed({9'b0, norm});

    if (ea == '0 || eb == '0) begin
      y = {s, 31'b0};
    end else if (ea == '1 || eb == '1) begin
      y = {s, 8'hFF, 23'b0};
    end else if (exp_s <= 10'sd0) begin
      y = {s, 31'b0};
    end else if (exp_s >= 10'sd255) begin
      y = {s, 8'hFF, 23'b0};
    end else begin
      y = {s, exp_s[7:0], man};
    end
  end

  // Truncation discards the low product bits.
  assign unused_low = ^prod[22:0];

endmodule

// File: rtl/taylor_term_gen.sv
// Sequential generator of exp(x) Taylor terms x^k/k!, k = 0..N-1.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : request, sampled in IDLE only
//   x, n_terms    : operand and requested term count (clamped to N_MAX)
//   busy          : run in progress (through DONE)
//   term_valid/term_ready/term_data/term_idx/term_last : term stream
//   done          : one-cycle completion pulse
// One shared multiplier: TERM computes p*rf[k], POW computes p*x.
module taylor_term_gen
  import taylor_pkg::*;
#(
  parameter int unsigned N_MAX = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      x,
  input  logic [3:0]       n_terms,
  output logic             busy,
  output logic             term_valid,
  input  logic             term_ready,
  output logic [31:0]      term_data,
  output logic [IDX_W-1:0] term_idx,
  output logic             term_last,
  output logic             done
);

  localparam int unsigned CNT_W   = 4;
  localparam logic [CNT_W-1:0] N_MAX_C = CNT_W'(N_MAX);

  state_e             state_q, state_d;
  logic [31:0]        x_q, x_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic [31:0]        p_q, p_d;
  logic [31:0]        data_q, data_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               last_q, last_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [31:0]        mul_b;
  logic [31:0]        mul_y;
  logic [CNT_W-1:0]   n_req;
  logic [CNT_W-1:0]   k_ext;

  assign mul_b = (state_q == POW) ? x_q : RF_ROM[k_q];
  assign n_req = (n_terms > N_MAX_C) ? N_MAX_C : n_terms;
  assign k_ext = CNT_W'(k_q);

  fp_mul32 u_mul (
    .a (p_q),
    .b (mul_b),
    .y (mul_y)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    n_d     = n_q;
    k_d     = k_q;
    p_d     = p_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d    = x;
          n_d    = n_req;
          k_d    = '0;
          p_d    = ONE_F;
          busy_d = 1'b1;
          if (n_req == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = TERM;
          end
        end
      end
      TERM: begin
        data_d  = mul_y;
        idx_d   = k_q;
        last_d  = (k_ext == n_q - CNT_W'(1));
        valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (term_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = POW;
          end
        end
      end
      POW: begin
        p_d     = mul_y;
        k_d     = k_q + IDX_W'(1);
        state_d = TERM;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      p_q     <= ONE_F;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      n_q     <= n_d;
      k_q     <= k_d;
      p_q     <= p_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign term_valid = valid_q;
  assign term_data  = data_q;
  assign term_idx   = idx_q;
  assign term_last  = last_q;
  assign done       = done_q;

endmodule

// File: tb/tb_taylor_term_gen.sv
module tb_taylor_term_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] x;
  logic [3:0]  n_terms;
  logic        busy;
  logic        term_valid;
  logic        term_ready;
  logic [31:0] term_data;
  logic [2:0]  term_idx;
  logic        term_last;
  logic        done;

  int vec  = 0;
  int miss = 0;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  exp_t q[$];

  taylor_term_gen #(.N_MAX(8), .IDX_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .x          (x),
    .n_terms    (n_terms),
    .busy       (busy),
    .term_valid (term_valid),
    .term_ready (term_ready),
    .term_data  (term_data),
    .term_idx   (term_idx),
    .term_last  (term_last),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic [31:0] d, input logic [2:0] i, input logic l);
    exp_t e;
    e.data = d;
    e.idx  = i;
    e.last = l;
    q.push_back(e);
  endtask

  // Starts a run at a negedge and consumes the stream; stalls term_ready for
  // stall_len cycles at stall_idx; pulses start again at cycle poke_cyc.
  task automatic run_seq(input logic [31:0] xv, input logic [3:0] nv,
                         input int stall_idx, input int stall_len, input int poke_cyc);
    exp_t        e;
    int          cyc;
    int          last_hs;
    int          stall_cnt;
    bit          seen;
    bit          fin;
    logic [31:0] held_d;
    logic [2:0]  held_i;
    x = xv; n_terms = nv; term_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (poke_cyc >= 0) n_terms = 4'd8;
    vec++;
    if (busy !== 1'b1) begin
      miss++; $display("FAIL busy_after_start: got %b want 1", busy);
    end
    if (nv == 4'd0) begin
      vec++;
      if (done !== 1'b1 || term_valid !== 1'b0) begin
        miss++; $display("FAIL zero_req_done: done=%b valid=%b want done=1 valid=0", done, term_valid);
      end
      @(negedge clk);
      vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miss++; $display("FAIL zero_req_end: done=%b busy=%b want 0 0", done, busy);
      end
      return;
    end
    cyc = 0; last_hs = -1; stall_cnt = 0; seen = 0; fin = 0;
    held_d = '0; held_i = '0;
    while (!fin && cyc < 400) begin
      vec++;
      if (done !== 1'b0) begin
        miss++; $display("FAIL done_early: cyc %0d got %b want 0", cyc, done);
      end
      if (term_valid === 1'b1) begin
        if (!seen) begin
          seen = 1;
          vec++;
          if (cyc != 1) begin
            miss++; $display("FAIL first_latency: got cyc %0d want 1", cyc);
          end
        end
        if (int'(term_idx) == stall_idx && stall_cnt < stall_len) begin
          if (stall_cnt > 0) begin
            vec++;
            if (term_data !== held_d || term_idx !== held_i) begin
              miss++; $display("FAIL stall_hold: got %h/%0d want %h/%0d", term_data, term_idx, held_d, held_i);
            end
          end
          held_d = term_data; held_i = term_idx;
          term_ready = 1'b0;
          stall_cnt++;
        end else begin
          term_ready = 1'b1;
          if (q.size() == 0) begin
            vec++; miss++;
            $display("FAIL extra_term: got idx %0d data %h want none", term_idx, term_data);
            fin = 1;
          end else begin
            e = q.pop_front();
            vec++;
            if (term_data !== e.data || term_idx !== e.idx || term_last !== e.last) begin
              miss++;
              $display("FAIL term: got %h idx %0d last %b want %h idx %0d last %b",
                       term_data, term_idx, term_last, e.data, e.idx, e.last);
            end
            if (stall_len == 0 && last_hs >= 0) begin
              vec++;
              if (cyc - last_hs != 3) begin
                miss++; $display("FAIL term_rate: got gap %0d want 3", cyc - last_hs);
              end
            end
            last_hs = cyc;
            if (e.last) fin = 1;
          end
        end
      end
      start = (cyc == poke_cyc);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    term_ready = 1'b1;
    if (!fin) begin
      vec++; miss++; $display("FAIL timeout: got %0d cycles want end of sequence", cyc);
    end
    vec++;
    if (done !== 1'b1 || term_valid !== 1'b0) begin
      miss++; $display("FAIL done_pulse: done=%b valid=%b want 1 0", done, term_valid);
    end
    @(negedge clk);
    vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miss++; $display("FAIL done_end: done=%b busy=%b want 0 0", done, busy);
    end
    vec++;
    if (q.size() != 0) begin
      miss++; $display("FAIL missing_terms: got %0d left want 0", q.size());
    end
    q.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; x = '0; n_terms = '0; term_ready = 1'b1;
    #1;
    vec++;
    if ({busy, term_valid, term_last, done} !== 4'b0 || term_data !== 32'h0 || term_idx !== 3'd0) begin
      miss++;
      $display("FAIL reset: busy=%b valid=%b last=%b done=%b data=%h idx=%0d want all 0",
               busy, term_valid, term_last, done, term_data, term_idx);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_x3;
    push_exp(32'h3F800000, 3'd0, 1'b0);
    push_exp(32'h40400000, 3'd1, 1'b0);
    push_exp(32'h40900000, 3'd2, 1'b0);
    push_exp(32'h40900000, 3'd3, 1'b0);
    push_exp(32'h40580000, 3'd4, 1'b1);
    run_seq(32'h40400000, 4'd5, -1, 0, -1);
  endtask

  task automatic test_stall;
    push_exp(32'h3F800000, 3'd0, 1'b0);
    push_exp(32'h40400000, 3'd1, 1'b0);
    push_exp(32'h40900000, 3'd2, 1'b0);
    push_exp(32'h40900000, 3'd3, 1'b0);
    push_exp(32'h40580000, 3'd4, 1'b1);
    run_seq(32'h40400000, 4'd5, 2, 4, -1);
  endtask

  task automatic test_zero_and_clamp;
    logic [31:0] rom [0:7];
    run_seq(32'h40400000, 4'd0, -1, 0, -1);
    rom = '{32'h3F800000, 32'h3F800000, 32'h3F000000, 32'h3E2AAAAB,
            32'h3D2AAAAB, 32'h3C088889, 32'h3AB60B61, 32'h39500D01};
    for (int i = 0; i < 8; i++) push_exp(rom[i], 3'(i), i == 7);
    run_seq(32'h3F800000, 4'd12, -1, 0, -1);
  endtask

  task automatic test_negative;
    push_exp(32'h3F800000, 3'd0, 1'b0);
    push_exp(32'hC0000000, 3'd1, 1'b0);
    push_exp(32'h40000000, 3'd2, 1'b0);
    push_exp(32'hBFAAAAAB, 3'd3, 1'b1);
    run_seq(32'hC0000000, 4'd4, -1, 0, -1);
  endtask

  task automatic test_special;
    push_exp(32'h3F800000, 3'd0, 1'b0);
    push_exp(32'h00000000, 3'd1, 1'b1);
    run_seq(32'h00000000, 4'd2, -1, 0, -1);
    push_exp(32'h3F800000, 3'd0, 1'b0);
    push_exp(32'h7F000000, 3'd1, 1'b0);
    push_exp(32'h7F800000, 3'd2, 1'b1);
    run_seq(32'h7F000000, 4'd3, -1, 0, -1);
  endtask

  task automatic test_start_busy;
    push_exp(32'h3F800000, 3'd0, 1'b0);
    push_exp(32'h3F800000, 3'd1, 1'b0);
    push_exp(32'h3F000000, 3'd2, 1'b1);
    run_seq(32'h3F800000, 4'd3, -1, 0, 4);
  endtask

  task automatic test_abort;
    bit hit;
    hit = 0;
    x = 32'h40400000; n_terms = 4'd5; term_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (term_valid === 1'b1 && term_idx === 3'd2) begin
        hit = 1;
        term_ready = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    vec++;
    if (!hit) begin
      miss++; $display("FAIL abort_reach: got no idx 2 want idx 2 within 40 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({busy, term_valid, term_last, done} !== 4'b0 || term_data !== 32'h0 || term_idx !== 3'd0) begin
      miss++;
      $display("FAIL abort_async: busy=%b valid=%b last=%b done=%b data=%h idx=%0d want all 0",
               busy, term_valid, term_last, done, term_data, term_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    term_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vec++;
      if (done !== 1'b0 || term_valid !== 1'b0 || busy !== 1'b0) begin
        miss++; $display("FAIL abort_quiet: done=%b valid=%b busy=%b want 0 0 0", done, term_valid, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_x3();
    test_stall();
    test_zero_and_clamp();
    test_negative();
    test_special();
    test_start_busy();
    test_abort();
    test_x3();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
